// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding selects and stall/flush control for the 5-stage core.
// Define HAZARD_FWD_EN to enable forwarding; otherwise the unit is interlock-only.
module hazard_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_d,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  regwrite_d,
   input  logic [1:0]            resultsrc_d,
   input  logic                  pcsrc_e,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e
);
   logic [REG_ADDR_W-1:0] rd_e, rd_m;
   logic                  regwrite_e, regwrite_m;
   logic                  taken, hazard, take_d;
   // regwrite is stored already qualified by rd!=0, so x0 never matches downstream
   assign taken = rst_n & pcsrc_e;
   assign take_d = valid_d & ~flush_e;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_e       <= '0;
         regwrite_e <= 1'b0;
         rd_m       <= '0;
         regwrite_m <= 1'b0;
      end else begin
         rd_e       <= take_d ? rd_d : '0;
         regwrite_e <= take_d & regwrite_d & (rd_d != '0);
         rd_m       <= rd_e;
         regwrite_m <= regwrite_e;
      end
   end
   assign stall_f = hazard & ~taken;
   assign stall_d = hazard & ~taken;
   assign flush_d = taken;
   assign flush_e = hazard | taken;
`ifdef HAZARD_FWD_EN
   logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_w;
   logic                  is_load_e, regwrite_w;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e      <= '0;
         rs2_e      <= '0;
         is_load_e  <= 1'b0;
         rd_w       <= '0;
         regwrite_w <= 1'b0;
      end else begin
         rs1_e      <= take_d ? rs1_d : '0;
         rs2_e      <= take_d ? rs2_d : '0;
         is_load_e  <= take_d & (resultsrc_d == 2'b01);
         rd_w       <= rd_m;
         regwrite_w <= regwrite_m;
      end
   end
   function automatic logic [1:0] fsel(input logic [REG_ADDR_W-1:0] rs);
      return (rs == '0) ? 2'b00 :
             (regwrite_m && rd_m == rs) ? 2'b10 :
             (regwrite_w && rd_w == rs) ? 2'b01 : 2'b00;
   endfunction
   assign fwd_a_e = fsel(rs1_e);
   assign fwd_b_e = fsel(rs2_e);
   assign hazard = valid_d & is_load_e & regwrite_e & ((rd_e == rs1_d) | (rd_e == rs2_d));
`else
   logic unused_resultsrc;
   assign unused_resultsrc = ^resultsrc_d;
   assign fwd_a_e = 2'b00;
   assign fwd_b_e = 2'b00;
   // without forwarding, any producer still in E or M must be waited out
   assign hazard = valid_d & ((regwrite_e & ((rd_e == rs1_d) | (rd_e == rs2_d))) |
                              (regwrite_m & ((rd_m == rs1_d) | (rd_m == rs2_d))));
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit; expectations follow HAZARD_FWD_EN.
module tb_hazard_unit;
   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } ins_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_d = 1'b0;
   logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
   logic       regwrite_d = 1'b0;
   logic [1:0] resultsrc_d = '0;
   logic       pcsrc_e = 1'b0;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic       stall_f, stall_d, flush_d, flush_e;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sbq[$];
   ins_t       h[3];
   logic       last_stall = 1'b0;

   hazard_unit #(.REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d), .pcsrc_e(pcsrc_e),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .flush_e(flush_e)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic wr, input logic ld);
      ins_t i;
      i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd); i.wr = wr; i.ld = ld;
      return i;
   endfunction

   function automatic bit writes(input ins_t x, input logic [4:0] r);
      return x.v && x.wr && x.rd != 5'd0 && x.rd == r;
   endfunction

   function automatic logic [1:0] mfwd(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
      if (rs == 5'd0) return 2'b00;
      if (writes(h[1], rs)) return 2'b10;
      if (writes(h[2], rs)) return 2'b01;
`endif
      return 2'b00;
   endfunction

   function automatic logic [7:0] model(input ins_t i, input logic pc);
      logic lw;
`ifdef HAZARD_FWD_EN
      lw = i.v && h[0].ld && (writes(h[0], i.rs1) || writes(h[0], i.rs2));
`else
      lw = i.v && (writes(h[0], i.rs1) || writes(h[0], i.rs2) ||
                   writes(h[1], i.rs1) || writes(h[1], i.rs2));
`endif
      return {mfwd(h[0].rs1), mfwd(h[0].rs2), lw & ~pc, lw & ~pc, pc, lw | pc};
   endfunction

   task automatic drive(input ins_t i, input logic pc);
      valid_d = i.v; rs1_d = i.rs1; rs2_d = i.rs2; rd_d = i.rd;
      regwrite_d = i.wr; resultsrc_d = i.ld ? 2'b01 : 2'b00; pcsrc_e = pc;
   endtask

   task automatic step(input ins_t i, input logic pc);
      logic [7:0] ev, obs;
      drive(i, pc);
      ev = model(i, pc);
      sbq.push_back(ev);
      last_stall = ev[3];
      @(negedge clk);
      obs = {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e};
      ev = sbq.pop_front();
      check("fwd_a", 8'(obs[7:6]), 8'(ev[7:6]));
      check("fwd_b", 8'(obs[5:4]), 8'(ev[5:4]));
      check("stall_f", 8'(obs[3]), 8'(ev[3]));
      check("stall_d", 8'(obs[2]), 8'(ev[2]));
      check("flush_d", 8'(obs[1]), 8'(ev[1]));
      check("flush_e", 8'(obs[0]), 8'(ev[0]));
      @(posedge clk);
      h[2] = h[1];
      h[1] = h[0];
      h[0] = (ev[0] || !i.v) ? '0 : i;
      #1;
   endtask

   // re-presents a stalled instruction, as the held IF/ID register would
   task automatic issue(input ins_t i, input logic pc = 1'b0);
      int n = 0;
      do begin
         step(i, pc);
         n++;
      end while (last_stall && n < 4);
      if (last_stall) check("stall_bound", 8'd1, 8'd0);
   endtask

   task automatic nop();
      issue(mk(0, 0, 0, 0, 0, 0));
   endtask

   task automatic rst_check(input string tag);
      sbq.push_back(8'h00);
      check(tag, {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e}, sbq.pop_front());
   endtask

   initial begin
      for (int k = 0; k < 3; k++) h[k] = '0;
      drive(mk(1, 5, 5, 6, 1, 1), 1'b1);
      #2 rst_check("reset_out");
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
      // back-to-back ALU dependency
      issue(mk(1, 1, 2, 5, 1, 0));
      issue(mk(1, 5, 7, 6, 1, 0));
      nop(); nop(); nop();
      // one-apart dependency, then M and W both writing x5
      issue(mk(1, 1, 2, 5, 1, 0));
      nop();
      issue(mk(1, 1, 5, 8, 1, 0));
      issue(mk(1, 1, 2, 5, 1, 0));
      issue(mk(1, 0, 0, 5, 1, 0));
      issue(mk(1, 1, 5, 8, 1, 0));
      nop(); nop(); nop();
      // load-use
      issue(mk(1, 1, 0, 5, 1, 1));
      issue(mk(1, 5, 1, 6, 1, 0));
      nop(); nop(); nop();
      // x0 destination
      issue(mk(1, 1, 0, 0, 1, 1));
      issue(mk(1, 0, 0, 6, 1, 0));
      nop(); nop(); nop();
      // taken branch coincident with load-use; squashed x6 must not forward
      issue(mk(1, 1, 0, 5, 1, 1));
      issue(mk(1, 5, 1, 6, 1, 0), 1'b1);
      issue(mk(1, 6, 6, 9, 1, 0));
      nop(); nop(); nop();
      // reset with x5 pending in M
      issue(mk(1, 1, 2, 5, 1, 0));
      nop();
      drive(mk(1, 5, 5, 6, 1, 0), 1'b1);
      #2 rst_n = 1'b0;
      #1 rst_check("async_rst");
      for (int k = 0; k < 3; k++) h[k] = '0;
      @(posedge clk); #1 rst_check("rst_held");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(mk(1, 5, 5, 6, 1, 0));
      nop(); nop();
      // random mix over a small register set
      for (int n = 0; n < 80; n++)
         issue(mk(($urandom % 8) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom % 4 != 0, $urandom % 3 == 0),
               ($urandom % 10) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #90000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. Tracks destination registers of in-flight instructions in its own E/M/W shadow pipeline and produces the 2-bit select codes for the execute-stage operand 4:1 multiplexers. Also produces fetch/decode stall and decode/execute flush controls. Sits beside the datapath, fed by decode-stage fields and the execute-stage branch outcome.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_d  in  1  decode stage holds a real instruction.
- rs1_d, rs2_d  in  REG_ADDR_W  decode-stage source registers.
- rd_d  in  REG_ADDR_W  decode-stage destination register.
- regwrite_d  in  1  decode instruction writes rd.
- resultsrc_d  in  2  decode result source; 2'b01 = load.
- pcsrc_e  in  1  branch/jump taken in execute.
- fwd_a_e, fwd_b_e  out  2  operand A/B select: 00 register file, 01 writeback result, 10 memory-stage ALU result; 11 never driven.
- stall_f, stall_d  out  1  hold PC / hold IF-ID register.
- flush_d, flush_e  out  1  clear IF-ID / ID-EX register.

## Operation
- Shadow pipeline per stage: E holds {rs1, rs2, rd, regwrite, is_load}; M and W hold {rd, regwrite}. Any register with rd==0 is treated as non-writing.
- Each rising edge: W<=M, M<=E, E<=(flush_e ? bubble : decode fields). A bubble has regwrite=0, is_load=0, and rs1=rs2=0. An invalid decode (valid_d=0) loads as a bubble.
- Forwarding, evaluated independently for A (rs1_e) and B (rs2_e), with priority M over W:
  - 10 if regwrite_m and rd_m==rs_e and rs_e!=0.
  - else 01 if regwrite_w and rd_w==rs_e and rs_e!=0.
  - else 00.
- Load-use: lwstall = valid_d & is_load_e & regwrite_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- stall_f = stall_d = lwstall & ~pcsrc_e.
- flush_d = pcsrc_e.
- flush_e = lwstall | pcsrc_e.
- Simultaneous taken branch and load-use: the flush wins, so no stall is asserted, and both flush_d and flush_e are asserted.
- The register file is write-first within a cycle, so a W-to-D dependency needs no action.

## Timing
- The fwd_* outputs are combinational from shadow registers only. They are valid from the start of the cycle in which the consumer is in E.
- stall/flush outputs are combinational from the shadow registers and the current-cycle decode/pcsrc_e inputs. They have zero latency and must be sampled by datapath registers on the same edge.
- A load-use hazard costs exactly 1 stall cycle. The next cycle forwards 01 from W.
- Reset, asynchronous: all shadow stages become bubbles immediately, and all outputs are 0.
  - Asserting reset mid-operation discards all tracking.
  - After deassertion, the first valid instruction sees no hazards.

## Configuration
- HAZARD_FWD_EN defined: forwarding and load-use behaviour as above.
- HAZARD_FWD_EN undefined: fwd_a_e and fwd_b_e are tied to 00, and the unit is interlock-only.
  - Interlock condition: valid_d and a decode source matches a writing rd in E or M (rd!=0).
  - On that condition, stall_f=stall_d=1 and flush_e=1, held until the match clears. This gives up to 2 stall cycles per dependency.
  - Branch-flush priority is unchanged.

## Test plan
- Back-to-back ALU ops: add x5 then sub x6,x5,x7 → fwd_a_e=10 when sub is in E; fwd_b_e=00; no stall.
- One-apart dependency: add x5, nop, or x8,x1,x5 → fwd_b_e=01 for or; both M and W writing x5 → 10 (M priority).
- Load-use: lw x5 then add x6,x5,x1 → 1 cycle with stall_f=stall_d=flush_e=1, then fwd_a_e=01.
- x0 destination: lw x0 then add x6,x0,x0 → no stall, fwd=00.
- Taken branch coincident with load-use → flush_d=flush_e=1, stall_f=stall_d=0; the squashed instruction produces no later forwarding.
- Reset asserted with x5 pending in M → all outputs 0 immediately. After release, add x6,x5,x5 gets fwd=00. Also run with HAZARD_FWD_EN undefined: back-to-back dependency → 2 stall cycles, fwd=00.
